// File: rtl/joypad_poller.sv
// rtl/joypad_poller.sv - scheduled poller for two NES 4021 serial gamepads.
// Optional JOYPAD_DEBOUNCE_EN: publish a pad only after two identical consecutive polls.

module joypad_poller #(
  parameter int LATCH_CYCLES = 12,
  parameter int HALF_CYCLES  = 6
) (
  input  logic       clk_nes,
  input  logic       rst_nes,
  input  logic       poll_trigger,
  input  logic [1:0] pad_data,
  output logic       pad_latch,
  output logic [1:0] pad_clk,
  output logic [7:0] buttons_0,
  output logic [7:0] buttons_1,
  output logic       buttons_valid,
  output logic       busy
);

  localparam int MAX_CYCLES = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int PW = $clog2(MAX_CYCLES + 1);
  localparam logic [PW-1:0] LATCH_LOAD = PW'(LATCH_CYCLES - 1);
  localparam logic [PW-1:0] HALF_LOAD  = PW'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LATCH, CLK_LO, CLK_HI, DONE} state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic [2:0]    index;
  logic          pending;
  logic [1:0]    pad_meta;
  logic [1:0]    pad_sync;
  logic [7:0]    shift_0;
  logic [7:0]    shift_1;
  logic [7:0]    next_0;
  logic [7:0]    next_1;
  logic          publish_pulse;
  logic          finish_scan;

  // Last cycle of the 8th high phase: shift registers are complete here.
  assign finish_scan = (state == CLK_HI) && (phase == '0) && (index == 3'd7);

`ifdef JOYPAD_DEBOUNCE_EN
  logic [7:0] hist_0;
  logic [7:0] hist_1;

  always_comb begin
    next_0        = (shift_0 == hist_0) ? shift_0 : buttons_0;
    next_1        = (shift_1 == hist_1) ? shift_1 : buttons_1;
    publish_pulse = (next_0 != buttons_0) || (next_1 != buttons_1);
  end

  always_ff @(posedge clk_nes) begin
    if (rst_nes) begin
      hist_0 <= 8'h00;
      hist_1 <= 8'h00;
    end else if (finish_scan) begin
      hist_0 <= shift_0;
      hist_1 <= shift_1;
    end
  end
`else
  always_comb begin
    next_0        = shift_0;
    next_1        = shift_1;
    publish_pulse = 1'b1;
  end
`endif

  // Pins idle high, so the synchronizer resets to the released level.
  always_ff @(posedge clk_nes) begin
    if (rst_nes) begin
      pad_meta <= 2'b11;
      pad_sync <= 2'b11;
    end else begin
      pad_meta <= pad_data;
      pad_sync <= pad_meta;
    end
  end

  always_ff @(posedge clk_nes) begin
    if (rst_nes) begin
      state         <= IDLE;
      phase         <= '0;
      index         <= 3'd0;
      pending       <= 1'b0;
      shift_0       <= 8'h00;
      shift_1       <= 8'h00;
      pad_latch     <= 1'b0;
      pad_clk       <= 2'b00;
      buttons_0     <= 8'h00;
      buttons_1     <= 8'h00;
      buttons_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      buttons_valid <= 1'b0;
      if (poll_trigger && state != IDLE) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (poll_trigger || pending) begin
            pending   <= 1'b0;
            state     <= LATCH;
            phase     <= LATCH_LOAD;
            pad_latch <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LATCH: begin
          if (phase == '0) begin
            state     <= CLK_LO;
            phase     <= HALF_LOAD;
            index     <= 3'd0;
            pad_latch <= 1'b0;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        CLK_LO: begin
          if (phase == '0) begin
            shift_0[index] <= ~pad_sync[0];
            shift_1[index] <= ~pad_sync[1];
            state          <= CLK_HI;
            phase          <= HALF_LOAD;
            pad_clk        <= 2'b11;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        CLK_HI: begin
          if (phase == '0) begin
            pad_clk <= 2'b00;
            if (index == 3'd7) begin
              // Outputs are registered, so the result is published on DONE entry.
              state         <= DONE;
              buttons_0     <= next_0;
              buttons_1     <= next_1;
              buttons_valid <= publish_pulse;
            end else begin
              index <= index + 1'b1;
              state <= CLK_LO;
              phase <= HALF_LOAD;
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end
        DONE: begin
          // A queued request starts straight away so no idle cycle is inserted.
          if (poll_trigger || pending) begin
            pending   <= 1'b0;
            state     <= LATCH;
            phase     <= LATCH_LOAD;
            pad_latch <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
